// File: rtl/chorus_tap_reader_if.sv
// Sample-in / tap-out bundle of the chorus tap reader.
// The master drives samples and controls; the slave returns the interpolated tap.
`timescale 1ns/1ps
interface chorus_tap_reader_if;
  logic        i_valid;
  logic [15:0] i_data;
  logic        i_enable;
  logic [2:0]  i_rate;
  logic [2:0]  i_depth;
  logic [15:0] o_tap;
  logic        o_valid;
  logic        o_busy;

  modport master (
    output i_valid, i_data, i_enable, i_rate, i_depth,
    input  o_tap, o_valid, o_busy
  );

  modport slave (
    input  i_valid, i_data, i_enable, i_rate, i_depth,
    output o_tap, o_valid, o_busy
  );
endinterface

// File: rtl/chorus_tap_reader.sv
// Chorus delay line: writes each sample into a circular RAM and reads one
// LFO-modulated tap back as two adjacent words blended by linear interpolation.
`timescale 1ns/1ps
module chorus_tap_reader #(
  parameter int unsigned BUFFER_SIZE = 10240,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned BASE_DELAY  = 1200
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  chorus_tap_reader_if.slave   bus
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned PHASE_W = 24;
  localparam int unsigned TRI_W   = 15;
  localparam int unsigned OFFP_W  = 18;
  localparam int unsigned OFF_W   = 16;
  localparam int unsigned AW1     = ADDR_W + 1;
  localparam int unsigned DQ_W    = ADDR_W + 8;
  localparam int unsigned DIFF_W  = 17;
  localparam int unsigned PROD_W  = 26;
  localparam int unsigned STEP_W  = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_RD0,
    S_RD1,
    S_INTERP,
    S_OUT
  } state_e;

  state_e                     state_q;
  logic [ADDR_W-1:0]          wr_ptr_q;
  logic [ADDR_W-1:0]          wptr_s_q;
  logic [AW1-1:0]             fill_cnt_q;
  logic [PHASE_W-1:0]         phase_q;
  logic                       en_q;
  logic [2:0]                 rate_q;
  logic [2:0]                 depth_q;
  logic [ADDR_W-1:0]          a0_q;
  logic [ADDR_W-1:0]          a1_q;
  logic [ADDR_W-1:0]          di_q;
  logic [7:0]                 fr_q;
  logic signed [DATA_W-1:0]   s0_q;
  logic signed [DATA_W-1:0]   o_tap_q;
  logic                       o_valid_q;
  logic                       o_busy_q;

  logic signed [DATA_W-1:0]   mem [BUFFER_SIZE];
  logic signed [DATA_W-1:0]   ram_rdata_q;

  logic [ADDR_W-1:0]          wr_ptr_d;
  logic [TRI_W-1:0]           tri_d;
  logic [OFFP_W-1:0]          off_prod_d;
  logic [OFF_W-1:0]           off_d;
  logic [DQ_W-1:0]            dq8_d;
  logic [ADDR_W-1:0]          di_d;
  logic [7:0]                 fr_d;
  logic [AW1-1:0]             diff_d;
  logic [ADDR_W-1:0]          a0_d;
  logic [ADDR_W-1:0]          a1_d;
  logic [PHASE_W-1:0]         phase_d;
  logic signed [DIFF_W-1:0]   sdiff_d;
  logic signed [8:0]          frs_d;
  logic signed [PROD_W-1:0]   prod_d;
  logic signed [DATA_W-1:0]   y_d;
  logic                       mute_d;
  logic [ADDR_W-1:0]          ram_addr_d;
  logic                       ram_we_d;

  // Address arithmetic, LFO step, interpolation and RAM port steering.
  always_comb begin
    wr_ptr_d   = '0;
    tri_d      = '0;
    off_prod_d = '0;
    off_d      = '0;
    dq8_d      = '0;
    di_d       = '0;
    fr_d       = '0;
    diff_d     = '0;
    a0_d       = '0;
    a1_d       = '0;
    phase_d    = '0;
    sdiff_d    = '0;
    frs_d      = '0;
    prod_d     = '0;
    y_d        = '0;
    mute_d     = 1'b0;
    ram_addr_d = wr_ptr_q;
    ram_we_d   = 1'b0;

    wr_ptr_d = (wr_ptr_q == ADDR_W'(BUFFER_SIZE - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);

    // Triangle LFO folded from the top phase bits, scaled by depth in Q8 samples.
    tri_d      = phase_q[PHASE_W-1] ? ~phase_q[PHASE_W-2:8] : phase_q[PHASE_W-2:8];
    off_prod_d = OFFP_W'(tri_d) * OFFP_W'(depth_q);
    off_d      = OFF_W'(off_prod_d >> 2);
    dq8_d      = DQ_W'(BASE_DELAY * 256) + DQ_W'(off_d);
    di_d       = dq8_d[DQ_W-1:8];
    fr_d       = dq8_d[7:0];

    // Delay never exceeds the buffer, so one add-back of BUFFER_SIZE is enough.
    diff_d = {1'b0, wptr_s_q} - {1'b0, di_d};
    a0_d   = diff_d[ADDR_W] ? ADDR_W'(diff_d + AW1'(BUFFER_SIZE)) : diff_d[ADDR_W-1:0];
    a1_d   = (a0_d == '0) ? ADDR_W'(BUFFER_SIZE - 1) : a0_d - ADDR_W'(1);

    phase_d = en_q ? phase_q + PHASE_W'((STEP_W'(rate_q) + STEP_W'(1)) << 6) : '0;

    // Result stays between s0 and s1, so truncation cannot wrap.
    sdiff_d = DIFF_W'(ram_rdata_q) - DIFF_W'(s0_q);
    frs_d   = $signed({1'b0, fr_q});
    prod_d  = PROD_W'(sdiff_d) * PROD_W'(frs_d);
    y_d     = s0_q + DATA_W'(prod_d >>> 8);

    mute_d = !en_q || (fill_cnt_q < (AW1'(di_q) + AW1'(2)));

    case (state_q)
      S_IDLE:  begin
        ram_addr_d = wr_ptr_q;
        ram_we_d   = bus.i_valid;
      end
      S_RD0:   ram_addr_d = a0_q;
      S_RD1:   ram_addr_d = a1_q;
      default: ram_addr_d = wr_ptr_q;
    endcase
  end

  // Single-port delay RAM, read-first with a registered read port; never reset.
  always_ff @(posedge i_clk) begin
    if (ram_we_d) begin
      mem[ram_addr_d] <= bus.i_data;
    end
    ram_rdata_q <= mem[ram_addr_d];
  end

  // Control FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      wptr_s_q   <= '0;
      fill_cnt_q <= '0;
      phase_q    <= '0;
      en_q       <= 1'b0;
      rate_q     <= '0;
      depth_q    <= '0;
      a0_q       <= '0;
      a1_q       <= '0;
      di_q       <= '0;
      fr_q       <= '0;
      s0_q       <= '0;
      o_tap_q    <= '0;
      o_valid_q  <= 1'b0;
      o_busy_q   <= 1'b0;
    end else begin
      o_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_valid) begin
            en_q     <= bus.i_enable;
            rate_q   <= bus.i_rate;
            depth_q  <= bus.i_depth;
            wptr_s_q <= wr_ptr_q;
            wr_ptr_q <= wr_ptr_d;
            if (fill_cnt_q != AW1'(BUFFER_SIZE)) begin
              fill_cnt_q <= fill_cnt_q + AW1'(1);
            end
            o_busy_q <= 1'b1;
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          a0_q    <= a0_d;
          a1_q    <= a1_d;
          di_q    <= di_d;
          fr_q    <= fr_d;
          phase_q <= phase_d;
          state_q <= S_RD0;
        end
        S_RD0: state_q <= S_RD1;
        S_RD1: begin
          s0_q    <= ram_rdata_q;
          state_q <= S_INTERP;
        end
        S_INTERP: begin
          o_tap_q   <= mute_d ? '0 : y_d;
          o_valid_q <= 1'b1;
          state_q   <= S_OUT;
        end
        S_OUT: begin
          o_busy_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          o_busy_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_tap   = o_tap_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_busy  = o_busy_q;

endmodule

// File: tb/tb_chorus_tap_reader.sv
// Directed bench for chorus_tap_reader: a reference model queues the expected
// tap for every accepted sample and a negedge monitor checks each o_valid.
`timescale 1ns/1ps
module tb_chorus_tap_reader;

  localparam int BS   = 10240;
  localparam int BASE = 1200;

  logic clk = 1'b0;
  logic rst_n;

  chorus_tap_reader_if bus();

  chorus_tap_reader #(
    .BUFFER_SIZE (BS),
    .ADDR_W      (14),
    .BASE_DELAY  (BASE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial forever #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          n_pushed = 0;
  int          out_idx = 0;
  int          seg = 0;
  bit          force_zero = 1'b0;
  logic [15:0] exp_q[$];

  shortint     m_buf [BS];
  int          m_wp = 0;
  int          m_fill = 0;
  logic [23:0] m_phase = '0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Behavioural reference of one accepted sample; queues the expected tap.
  function automatic void model_push(input logic [15:0] x, input logic en,
                                     input logic [2:0] rate, input logic [2:0] depth);
    int wps, off, dq, di, fr, a0, a1, s0, s1, y;
    logic [14:0] tr;
    m_buf[m_wp] = x;
    wps  = m_wp;
    m_wp = (m_wp + 1) % BS;
    if (m_fill < BS) m_fill++;
    tr  = m_phase[23] ? ~m_phase[22:8] : m_phase[22:8];
    off = (int'(tr) * int'(depth)) >> 2;
    dq  = BASE * 256 + off;
    di  = dq / 256;
    fr  = dq % 256;
    a0  = (wps - di + BS) % BS;
    a1  = (a0 - 1 + BS) % BS;
    s0  = m_buf[a0];
    s1  = m_buf[a1];
    y   = s0 + (((s1 - s0) * fr) >>> 8);
    m_phase = en ? m_phase + 24'((int'(rate) + 1) * 64) : 24'd0;
    exp_q.push_back((!en || m_fill < di + 2) ? 16'd0 : 16'(y));
    n_pushed++;
  endfunction

  task automatic send(input logic [15:0] x, input logic en,
                      input logic [2:0] rate, input logic [2:0] depth);
    bus.i_valid  = 1'b1;
    bus.i_data   = x;
    bus.i_enable = en;
    bus.i_rate   = rate;
    bus.i_depth  = depth;
    model_push(x, en, rate, depth);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Output monitor: scoreboard pop plus fixed expectations at known indices.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && bus.o_valid) begin
      n_out++;
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_output: observed tap %h expected no output", bus.o_tap);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tap_model", bus.o_tap, e);
      end
      if (force_zero) check("disabled_tap", bus.o_tap, 16'd0);
      if (seg == 0) begin
        if (out_idx == 1209 || out_idx == 1211) check("impulse_neighbour", bus.o_tap, 16'd0);
        if (out_idx == 1210)  check("impulse_1210", bus.o_tap, 16'd1000);
        if (out_idx >= 2800 && out_idx < 2900) check("dc_interp", bus.o_tap, 16'hB1E0);
        if (out_idx == 11435) check("wrap_11435", bus.o_tap, 16'd500);
      end else begin
        if (out_idx < 1201) check("refill_zero", bus.o_tap, 16'd0);
      end
      out_idx++;
    end
  end

  initial begin
    int          out_snap;
    logic [15:0] tmp;
    rst_n        = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_data   = '0;
    bus.i_enable = 1'b1;
    bus.i_rate   = '0;
    bus.i_depth  = '0;

    // Held in reset while i_valid toggles.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.i_valid = ~bus.i_valid;
      bus.i_data  = 16'($urandom);
      check("rst_tap",   bus.o_tap, 16'd0);
      check("rst_valid", {15'd0, bus.o_valid}, 16'd0);
      check("rst_busy",  {15'd0, bus.o_busy}, 16'd0);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // First sample: o_valid exactly five cycles later, busy throughout.
    bus.i_valid = 1'b1;
    bus.i_data  = 16'd0;
    model_push(16'd0, 1'b1, 3'd0, 3'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      check("latency_valid", {15'd0, bus.o_valid}, {15'd0, (k == 5)});
      check("latency_busy",  {15'd0, bus.o_busy}, 16'd1);
    end
    @(negedge clk);
    check("idle_busy", {15'd0, bus.o_busy}, 16'd0);

    // Fixed delay with an impulse at sample 10.
    for (int s = 1; s < 1300; s++) send((s == 10) ? 16'd1000 : 16'd0, 1'b1, 3'd0, 3'd0);
    // Deep fast modulation on DC.
    for (int s = 1300; s < 2900; s++) send(16'hB1E0, 1'b1, 3'd7, 3'd7);
    // Full-scale alternation.
    for (int s = 2900; s < 3200; s++) send(s[0] ? 16'h8000 : 16'h7FFF, 1'b1, 3'd7, 3'd7);
    // Random data and random modulation settings.
    for (int s = 3200; s < 3500; s++) send(16'($urandom), 1'b1, 3'($urandom), 3'($urandom));
    // Fixed delay again; impulse near the top of the buffer crosses the wrap.
    for (int s = 3500; s < 11440; s++) send((s == 10235) ? 16'd500 : 16'd0, 1'b1, 3'd0, 3'd0);

    // Disabled: tap forced to zero, LFO cleared.
    force_zero = 1'b1;
    for (int i = 0; i < 20; i++) send(16'($urandom), 1'b0, 3'd5, 3'd7);
    force_zero = 1'b0;

    // A second strobe two cycles after an accepted one must be ignored.
    bus.i_valid  = 1'b1;
    bus.i_data   = 16'h1234;
    bus.i_enable = 1'b1;
    bus.i_rate   = 3'd3;
    bus.i_depth  = 3'd7;
    model_push(16'h1234, 1'b1, 3'd3, 3'd7);
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h3039;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (13) @(negedge clk);
    check("dropped_count", 16'(n_out), 16'(n_pushed));
    for (int i = 0; i < 30; i++) send(16'($urandom), 1'b1, 3'd3, 3'd7);

    // Reset while the FSM is in RD1: no output for that sample.
    out_snap     = n_out;
    bus.i_valid  = 1'b1;
    bus.i_data   = 16'd777;
    bus.i_enable = 1'b1;
    bus.i_rate   = 3'd0;
    bus.i_depth  = 3'd0;
    tmp          = 16'd777;
    m_buf[m_wp]  = tmp;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", {15'd0, bus.o_valid}, 16'd0);
    check("midrst_busy",  {15'd0, bus.o_busy}, 16'd0);
    check("midrst_tap",   bus.o_tap, 16'd0);
    rst_n   = 1'b1;
    m_wp    = 0;
    m_fill  = 0;
    m_phase = '0;
    seg     = 1;
    out_idx = 0;
    repeat (10) @(negedge clk);
    check("midrst_no_output", 16'(n_out), 16'(out_snap));
    for (int s = 0; s < 1215; s++) send(16'(s + 1), 1'b1, 3'd0, 3'd0);

    repeat (10) @(negedge clk);
    check("pending_expect", 16'(exp_q.size()), 16'd0);
    check("output_count", 16'(n_out), 16'(n_pushed));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
